// File: rtl/rr_arb_pkg.sv
// Shared constants and FSM state type for the round-robin mux arbiter.
package rr_arb_pkg;

  localparam int unsigned NUM_REQ = 8;
  localparam int unsigned SEL_W   = 3;
  // Wide enough for HOLD_CYCLES-1 with HOLD_CYCLES up to 16.
  localparam int unsigned CNT_W   = 4;

  typedef enum logic [0:0] {
    IDLE,
    GRANT
  } arb_state_e;

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating-priority search: first set req bit above last, wrapping; last itself is lowest.
module rr_priority_pick
  import rr_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   last,
  output logic [SEL_W-1:0]   idx,
  output logic               found
);

  logic [SEL_W-1:0] w_cand;

  always_comb begin
    found  = |req;
    idx    = '0;
    w_cand = '0;
    // Walk from farthest to nearest so the nearest hit above last wins.
    for (int unsigned i = NUM_REQ; i > 0; i--) begin
      w_cand = last + SEL_W'(i);
      if (req[w_cand]) begin
        idx = w_cand;
      end
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter with per-grant hold limit and shared 8:1 data mux.
// Optional grant lock enabled by defining RR_MUX_ARBITER_LOCK_EN.
module rr_mux_arbiter
  import rr_arb_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] reqIn,
  input  logic [NUM_REQ-1:0] dataIn,
`ifdef RR_MUX_ARBITER_LOCK_EN
  input  logic               lockIn,
`endif
  output logic [NUM_REQ-1:0] grantOut,
  output logic               grantValid,
  output logic [SEL_W-1:0]   selectLine,
  output logic               dataOut
);

  arb_state_e         r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
  logic               r_valid, w_valid_nxt;
  logic [SEL_W-1:0]   r_sel, w_sel_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [SEL_W-1:0]   r_last, w_last_nxt;

  logic [SEL_W-1:0]   w_search_from;
  logic [SEL_W-1:0]   w_pick_idx;
  logic               w_pick_found;
  logic               w_lock;
  logic               w_release;

`ifdef RR_MUX_ARBITER_LOCK_EN
  assign w_lock = lockIn;
`else
  assign w_lock = 1'b0;
`endif

  // While granted, the current grantee becomes the lowest-priority slot for the next search.
  assign w_search_from = (r_state == GRANT) ? r_sel : r_last;

  rr_priority_pick u_pick (
    .req   (reqIn),
    .last  (w_search_from),
    .idx   (w_pick_idx),
    .found (w_pick_found)
  );

  assign w_release = !reqIn[r_sel] || ((r_cnt == '0) && !w_lock);

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_valid_nxt = r_valid;
    w_sel_nxt   = r_sel;
    w_cnt_nxt   = r_cnt;
    w_last_nxt  = r_last;

    unique case (r_state)
      IDLE: begin
        if (w_pick_found) begin
          w_state_nxt = GRANT;
          w_grant_nxt = NUM_REQ'(1) << w_pick_idx;
          w_valid_nxt = 1'b1;
          w_sel_nxt   = w_pick_idx;
          w_cnt_nxt   = CNT_W'(HOLD_CYCLES - 1);
        end
      end
      GRANT: begin
        if (w_release) begin
          w_last_nxt = r_sel;
          if (w_pick_found) begin
            w_grant_nxt = NUM_REQ'(1) << w_pick_idx;
            w_sel_nxt   = w_pick_idx;
            w_cnt_nxt   = CNT_W'(HOLD_CYCLES - 1);
          end else begin
            w_state_nxt = IDLE;
            w_grant_nxt = '0;
            w_valid_nxt = 1'b0;
            w_cnt_nxt   = '0;
          end
        end else if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = '0;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_valid <= 1'b0;
      r_sel   <= '0;
      r_cnt   <= '0;
      r_last  <= SEL_W'(NUM_REQ - 1);
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_valid <= w_valid_nxt;
      r_sel   <= w_sel_nxt;
      r_cnt   <= w_cnt_nxt;
      r_last  <= w_last_nxt;
    end
  end

  assign grantOut   = r_grant;
  assign grantValid = r_valid;
  assign selectLine = r_sel;
  assign dataOut    = r_valid ? dataIn[r_sel] : 1'b0;

endmodule

// File: doc/rr_mux_arbiter.md
RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 Parameter HOLD_CYCLES, default 4, SHALL set the maximum consecutive cycles one grant is held (legal range 1..16).
REQ-002 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-004 reqIn  input  8  SHALL carry one request bit per requester (index 0..7).
REQ-005 dataIn  input  8  SHALL carry one data bit per requester, routed through the shared 8:1 mux.
REQ-006 grantOut  output  8  SHALL be the one-hot grant (all zero when idle).
REQ-007 grantValid  output  1  SHALL be high whenever grantOut is non-zero.
REQ-008 selectLine  output  3  SHALL be the binary index of the current grantee.
REQ-009 dataOut  output  1  SHALL be dataIn[selectLine] when grantValid=1, else 0 (combinational, zero latency).

Function
REQ-010 FSM SHALL have two states: IDLE and GRANT.
REQ-011 IDLE -> GRANT on a clock edge when any reqIn bit is 1; IDLE SHALL persist while reqIn=0.
REQ-012 Winner SHALL be the first set reqIn bit searching upward from lastWinner+1, wrapping 7->0; lastWinner itself is lowest priority.
REQ-013 grantOut, grantValid and selectLine SHALL be registered; they update on the edge following the deciding cycle.
REQ-014 On grant, hold counter SHALL load HOLD_CYCLES-1 and decrement each GRANT cycle, saturating at 0.
REQ-015 Release condition: reqIn[selectLine]=0, or counter=0.
REQ-016 On release with other requests pending, the next grant SHALL be issued on the same edge (no idle bubble); lastWinner updates to the released index.
REQ-017 On release with no requests pending, the FSM SHALL return to IDLE and grantOut/grantValid SHALL clear.
REQ-018 A sole requester whose hold expires SHALL be re-granted immediately; grantValid SHALL stay high.
REQ-019 Requests arriving mid-grant SHALL not pre-empt the current grantee.
REQ-020 grantOut SHALL never have more than one bit set.

Reset
REQ-021 Reset SHALL force state=IDLE, grantOut=0, grantValid=0, selectLine=0, counter=0, lastWinner=7 (so the first search starts at index 0).
REQ-022 Reset asserted mid-grant SHALL drop grantOut/grantValid immediately, without waiting for a clock edge.
REQ-023 After reset deasserts, the first grant SHALL follow REQ-011 with no extra delay.

Configuration
REQ-024 Macro RR_MUX_ARBITER_LOCK_EN SHALL control the grant-lock feature.
REQ-025 With the macro defined, a 1-bit input lockIn SHALL exist; while lockIn=1 and reqIn[selectLine]=1, the counter release SHALL be suppressed (the grant is held indefinitely).
REQ-026 Without the macro, lockIn SHALL not exist and behaviour SHALL be exactly REQ-010..REQ-020.

Structure
REQ-027 Package rr_arb_pkg SHALL hold NUM_REQ=8, SEL_W=3, and the state enum type (IDLE, GRANT).
REQ-028 Rotating priority search SHALL live in a combinational sub-module rr_priority_pick, with inputs req[7:0] and last[2:0] and outputs idx[2:0] and found.
REQ-029 rr_mux_arbiter SHALL instantiate rr_priority_pick once and implement the FSM, counter and data mux itself.

Verification
REQ-030 After reset, reqIn=8'h01, dataIn=8'h01 -> next edge grantOut=8'h01, selectLine=0, dataOut=1, grantValid=1.
REQ-031 reqIn=8'hFF held, HOLD_CYCLES=4 -> grants 0,1,2,...,7,0 each lasting 4 cycles, no idle cycles between grants.
REQ-032 reqIn=8'h24 with lastWinner=2 -> grant 5; when reqIn[5] drops after 2 cycles -> grant 2 on that edge.
REQ-033 Only reqIn[3] held continuously -> selectLine=3 and grantValid=1 every cycle, with the counter reloading every 4 cycles.
REQ-034 Reset pulsed mid-grant with reqIn=8'h80 -> grantOut=0 immediately; after release -> grant 7 one edge later.
REQ-035 With RR_MUX_ARBITER_LOCK_EN defined, lockIn=1 and reqIn=8'h03 with grantee 0 -> grant 0 held 20+ cycles; lockIn=0 -> grant 1 within 4 cycles.
